el2_exu_mul_noc_sched: RTL

// Sequences one multiply transaction at a time between the EXU pipeline and the NoC multiplier path.

---
 rtl/el2_exu_mul_noc_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/el2_exu_mul_noc_sched.sv
// Sequences one multiply transaction at a time between the EXU pipeline and the NoC
// multiplier path: launch sender, stall until a result packet arrives, capture, flush.
module el2_exu_mul_noc_sched #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_noc,
   input  logic        rst_l,
   input  logic        mul_req,
   input  logic        mul_kill,
   input  logic        tx_ready,
   output logic        tx_start,
   input  logic        rx_valid,
   input  logic [31:0] rx_result,
   output logic        noc_sr_flush,
   output logic        mul_busy,
   output logic        result_valid,
   output logic [31:0] result_x,
   output logic        timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SEND  = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] RESP  = 3'd4;
   localparam logic [2:0] FLUSH = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      result_q, result_d;
   logic             terr_q, terr_d;
   logic             launch;
   logic             flush_pulse;
   logic             resp_pulse;
   logic             timeout_hit;
   logic             counting;

   assign timeout_hit = (cnt_q == CNT_LAST);
   assign counting    = (state_q == WAIT) || (state_q == DRAIN);

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      terr_d      = terr_q;
      launch      = 1'b0;
      flush_pulse = 1'b0;
      resp_pulse  = 1'b0;
      case (state_q)
         IDLE: begin
            // A kill in the same cycle as a request cancels it before anything is sent.
            if (mul_req && !mul_kill) begin
               if (tx_ready) begin
                  launch  = 1'b1;
                  state_d = WAIT;
               end else begin
                  state_d = SEND;
               end
            end
         end
         SEND: begin
            if (mul_kill) begin
               state_d = IDLE;
            end else if (tx_ready) begin
               launch  = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (mul_kill) begin
               state_d = rx_valid ? FLUSH : DRAIN;
            end else if (rx_valid) begin
               result_d = rx_result;
               state_d  = RESP;
            end else if (timeout_hit) begin
               terr_d  = 1'b1;
               state_d = FLUSH;
            end
         end
         DRAIN: begin
            // The packet of a killed request must still be consumed before the next launch.
            if (rx_valid) begin
               state_d = FLUSH;
            end else if (timeout_hit) begin
               terr_d  = 1'b1;
               state_d = FLUSH;
            end
         end
         RESP: begin
            flush_pulse = 1'b1;
            resp_pulse  = !mul_kill;
            state_d     = IDLE;
         end
         FLUSH: begin
            flush_pulse = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (launch) begin
         cnt_d = '0;
      end else if (counting && !timeout_hit) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_noc or negedge rst_l) begin
      if (!rst_l) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         terr_q   <= terr_d;
      end
   end

   // IDLE decodes inputs directly, so the launch strobe is qualified by reset as well.
   assign tx_start     = launch && rst_l;
   assign noc_sr_flush = flush_pulse;
   assign result_valid = resp_pulse;
   assign mul_busy     = (state_q != IDLE);
   assign result_x     = result_q;
   assign timeout_err  = terr_q;

endmodule
